// File: rtl/fetch_unit.sv
// Program-counter and instruction-fetch stage feeding the ctl decoder.
// Fetches one instruction at a time over a req/ack handshake and forms the next PC from pcsel.
module fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008,
    parameter int          IRQ_SYNC  = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  pcsel,
    input  logic [31:0] jt,
    input  logic        stall,
    input  logic        irq,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic        irq_take,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t              state_q;
    logic [31:0]         pc_q;
    logic [31:0]         instr_q;
    logic                instr_valid_q;
    logic                imem_req_q;
    logic                irq_take_q;
    logic [IRQ_SYNC-1:0] irq_sync_q;
    logic [31:0]         next_pc_d;
    logic [30:0]         br_off;
    logic                irq_sync;
    logic                unused_jt;

    assign irq_sync  = irq_sync_q[IRQ_SYNC-1];
    assign unused_jt = ^jt[1:0];

    // Low 31 bits wrap on their own; bit 31 (supervisor) is never touched by arithmetic.
    assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};
    assign br_off   = {{13{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        // NOTE: default assignment first so no path leaves next_pc_d unassigned (no latch).
        next_pc_d = ILLOP_VEC;
        case (pcsel)
            3'd0:    next_pc_d = pc_plus4;
            3'd1:    next_pc_d = {pc_q[31], pc_plus4[30:0] + br_off};
            3'd2:    next_pc_d = {pc_q[31] & jt[31], jt[30:2], 2'b00};
            3'd4:    next_pc_d = XADR_VEC;
            default: next_pc_d = ILLOP_VEC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_sync_q <= '0;
        end else begin
            irq_sync_q <= {irq_sync_q[IRQ_SYNC-2:0], irq};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VEC;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            irq_take_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        irq_take_q    <= irq_sync & ~pc_q[31];
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        pc_q          <= next_pc_d;
                        irq_take_q    <= 1'b0;
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                        state_q       <= FETCH;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b0;
                    irq_take_q    <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = {pc_q[31:2], 2'b00};
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign op          = instr_q[31:26];
    assign irq_take    = irq_take_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, wait states, branch/JMP/vector targets, IRQ gating, stall and reset abort.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  pcsel;
    logic [31:0] jt;
    logic        stall;
    logic        irq;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  op;
    logic        irq_take;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pcsel      (pcsel),
        .jt         (jt),
        .stall      (stall),
        .irq        (irq),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .op         (op),
        .irq_take   (irq_take),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH; leaves the DUT in EXEC with the fetched word latched.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata, input int nwait);
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < nwait; i++) begin
            tick();
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, exp_addr);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        check("exec_req", {31'd0, imem_req}, 32'd0);
        check("exec_instr", instr, rdata);
        check("exec_pc", pc, exp_addr);
    endtask

    task automatic retire(input logic [2:0] sel, input logic [31:0] jtv, input logic [31:0] exp_next);
        pcsel = sel;
        jt    = jtv;
        stall = 1'b0;
        tick();
        check("retire_valid", {31'd0, instr_valid}, 32'd0);
        check("retire_irq_take", {31'd0, irq_take}, 32'd0);
        check("retire_next_addr", imem_addr, exp_next);
        pcsel = 3'd0;
        jt    = 32'h0;
    endtask

    initial begin
        reset_n    = 1'b0;
        pcsel      = 3'd0;
        jt         = 32'h0;
        stall      = 1'b0;
        irq        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        repeat (3) tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_instr", instr, 32'h0);
        check("rst_irq_take", {31'd0, irq_take}, 32'd0);
        check("rst_pc_plus4", pc_plus4, 32'h8000_0004);

        // First fetch right after release
        reset_n = 1'b1;
        tick();
        do_fetch(32'h8000_0000, 32'hC3E0_0005, 0);
        check("t1_op", {26'd0, op}, 32'h30);
        check("t1_pc_plus4", pc_plus4, 32'h8000_0004);
        check("t1_irq_take", {31'd0, irq_take}, 32'd0);
        retire(3'd0, 32'h0, 32'h8000_0004);

        // Wait states with stall asserted (ignored outside EXEC)
        stall = 1'b1;
        do_fetch(32'h8000_0004, 32'h0000_0000, 3);
        stall = 1'b0;
        retire(3'd2, 32'h8000_0013, 32'h8000_0010);

        // JMP from supervisor to user mode
        do_fetch(32'h8000_0010, 32'h0000_0000, 0);
        retire(3'd2, 32'h0000_0203, 32'h0000_0200);

        // IRQ taken in user mode, then held through stall
        irq = 1'b1;
        do_fetch(32'h0000_0200, 32'h1111_2222, 3);
        check("irq_take_user", {31'd0, irq_take}, 32'd1);
        check("irq_pc_plus4", pc_plus4, 32'h0000_0204);
        stall      = 1'b1;
        irq        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_pc", pc, 32'h0000_0200);
            check("stall_instr", instr, 32'h1111_2222);
            check("stall_irq_take", {31'd0, irq_take}, 32'd1);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        retire(3'd4, 32'h0, 32'h8000_0008);

        // IRQ masked in supervisor mode
        irq = 1'b1;
        do_fetch(32'h8000_0008, 32'h0000_0000, 3);
        check("irq_masked_xadr", {31'd0, irq_take}, 32'd0);
        retire(3'd2, 32'h8000_0200, 32'h8000_0200);
        do_fetch(32'h8000_0200, 32'h0000_0000, 2);
        check("irq_masked_200", {31'd0, irq_take}, 32'd0);
        retire(3'd2, 32'h0000_0010, 32'h0000_0010);

        // JMP from user mode cannot gain supervisor
        irq = 1'b0;
        do_fetch(32'h0000_0010, 32'h0000_0000, 3);
        check("irq_low_user", {31'd0, irq_take}, 32'd0);
        retire(3'd2, 32'h8000_0040, 32'h0000_0040);
        do_fetch(32'h0000_0040, 32'h0000_0000, 0);
        retire(3'd2, 32'h0000_0100, 32'h0000_0100);

        // Backward branch, then wrap at the top of user space
        do_fetch(32'h0000_0100, 32'h0000_FFFE, 0);
        retire(3'd1, 32'h0, 32'h0000_00FC);
        do_fetch(32'h0000_00FC, 32'h0000_0000, 0);
        retire(3'd2, 32'h7FFF_FFFC, 32'h7FFF_FFFC);
        do_fetch(32'h7FFF_FFFC, 32'h0000_0000, 0);
        check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        retire(3'd1, 32'h0, 32'h0000_0000);

        // ILLOP and an unused pcsel code
        do_fetch(32'h0000_0000, 32'h0000_0000, 0);
        retire(3'd3, 32'h0, 32'h8000_0004);
        do_fetch(32'h8000_0004, 32'h0000_0000, 0);
        retire(3'd6, 32'h0, 32'h8000_0004);

        // Reset mid-FETCH; a late ack landing in IDLE is ignored
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_req", {31'd0, imem_req}, 32'd0);
        check("abort_pc", pc, 32'h8000_0000);
        check("abort_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        #2;
        reset_n = 1'b1;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("late_ack_req", {31'd0, imem_req}, 32'd1);
        check("late_ack_addr", imem_addr, 32'h8000_0000);
        check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("late_ack_valid2", {31'd0, instr_valid}, 32'd0);
        check("late_ack_instr", instr, 32'h0);
        do_fetch(32'h8000_0000, 32'h0400_0000, 0);
        check("final_op", {26'd0, op}, 32'h01);
        retire(3'd0, 32'h0, 32'h8000_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage that sits directly upstream of the control decoder `ctl`.
- Owns PC and the supervisor bit (PC[31]). Fetches each instruction from instruction memory over a req/ack handshake, presents the opcode and the gated interrupt to `ctl`, and consumes `ctl`'s pcsel to compute the next PC.
- Multicycle: one instruction is in flight at a time.

Parameters:
- RESET_VEC, 32'h80000000, PC loaded on reset; supervisor mode.
- ILLOP_VEC, 32'h80000004, target for pcsel=3 and for unused pcsel codes 5-7.
- XADR_VEC, 32'h80000008, interrupt target for pcsel=4.
- IRQ_SYNC, 2, number of irq synchroniser flops (≥2).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pcsel  in  3  next-PC select from ctl: 0=PC+4, 1=branch, 2=JMP, 3=ILLOP, 4=XADR.
- jt  in  32  JMP target (Ra register value).
- stall  in  1  datapath cannot retire the current instruction this cycle.
- irq  in  1  raw asynchronous interrupt request, level.
- imem_req  out  1  instruction read request.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  latched instruction.
- instr_valid  out  1  instr is valid; ctl outputs are meaningful.
- op  out  6  instr[31:26], to ctl.
- irq_take  out  1  gated interrupt, to ctl irq.
- pc  out  32  current instruction address.
- pc_plus4  out  32  {pc[31], pc[30:0]+4}; writeback value for LR/XP.

Behaviour:
- Reset (async assert, sync release). State=IDLE, pc=RESET_VEC, instr=0, instr_valid=0, imem_req=0, irq_take=0, synchroniser cleared. All outputs are registered or decoded from registered state. imem_req drops within the reset-assert time.
- IDLE → FETCH on the first clock after reset_n is high.
- FETCH:
  - imem_req=1; imem_addr={pc[31:2],2'b00}.
  - Address is held stable until ack; any wait length is legal.
  - On imem_ack: instr<=imem_rdata; irq_take<=irq_sync & ~pc[31]; go to EXEC.
  - Minimum latency is req to instr_valid = 1 cycle after ack.
- EXEC:
  - imem_req=0, instr_valid=1. instr and irq_take stay stable for the whole of EXEC.
  - stall=1: hold everything.
  - stall=0: retire. pc<=next_pc; instr_valid<=0; go to FETCH.
- next_pc by pcsel:
  - 0: pc_plus4.
  - 1: {pc[31], (pc_plus4[30:0] + {sext(instr[15:0]),2'b00}[30:0])}. Arithmetic is modulo 2^31; wrap is silent.
  - 2: {pc[31]&jt[31], jt[30:2], 2'b00}. JMP can clear the supervisor bit but never set it.
  - 3, 5, 6, 7: ILLOP_VEC.
  - 4: XADR_VEC.
- Supervisor bit: set only via the vectors; cleared only via JMP with jt[31]=0. pc_plus4 never carries into bit 31.
- IRQ handling:
  - irq passes through IRQ_SYNC flops.
  - Sampled only at the FETCH→EXEC transition; masked when pc[31]=1.
  - irq_take is cleared on retire.
  - irq deasserting during EXEC does not drop irq_take.
- Boundary conditions:
  - imem_ack outside FETCH is ignored.
  - Reset asserted during FETCH or EXEC aborts immediately. A late ack after release lands in IDLE and is ignored. Fetch restarts at RESET_VEC.
  - stall outside EXEC is ignored.
  - ack and reset in the same edge: reset wins.
  - imem_rdata bits are not checked; illegal opcodes are handled by ctl via pcsel.

Test Plan:
1. Release reset_n; cycle 1 after release shows imem_req=1, imem_addr=0x80000000. Ack with 0xC3E00005 → next cycle instr_valid=1, op=0x30, pc_plus4=0x80000004.
2. Sequential with wait states: ack delayed 3 cycles, pcsel=0, stall=0 → imem_addr held at 0x80000000 throughout, then next fetch at 0x80000004.
3. Branch: pc=0x00000100, instr[15:0]=0xFFFE, pcsel=1 → next imem_addr=0x000000FC. Same with pc=0x7FFFFFFC, offset 0 → 0x00000000, supervisor bit stays 0.
4. JMP: pc=0x80000010, jt=0x00000203 → 0x00000200 (user mode). pc=0x00000010, jt=0x80000040 → 0x00000040 (supervisor not gained).
5. IRQ: user pc=0x00000200, irq high ≥3 cycles before ack → irq_take=1; drive pcsel=4 → next 0x80000008, pc_plus4 during EXEC=0x00000204. Repeat at pc=0x80000200 → irq_take=0.
6. Stall/reset: stall=1 for 4 EXEC cycles → pc, instr, irq_take unchanged, no imem_req. Assert reset_n=0 mid-FETCH, ack arrives after release in IDLE → ignored, next imem_addr=0x80000000.
